// File: rtl/pwm_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_player
// Brief    : Windowed sample-ROM player with volume scaling and PWM output.
// Revision : 1.0
// ============================================================================
module pwm_sample_player #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int VOL_W      = 4,
    parameter int SAMPLE_DIV = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aud_en,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [VOL_W-1:0]  volume,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pwm,
    output logic              busy,
    output logic              done
);

    localparam int                c_TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int                c_GAIN_W    = VOL_W + 1;
    localparam int                c_PROD_W    = DATA_W + VOL_W + 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_DIV - 1);
    localparam logic [DATA_W-1:0] c_PWM_LAST  = {DATA_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_en_s;
    logic                r_en_d;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [DATA_W-1:0]   r_sample;
    logic [DATA_W-1:0]   r_pwm_cnt;
    logic [DATA_W-1:0]   r_duty;
    logic                r_pwm;
    logic                r_done;

    logic                w_rise;
    logic                w_fall;
    logic                w_tick;
    logic                w_at_end;
    logic                w_finish;
    logic                w_play_next;
    logic [c_GAIN_W-1:0] w_gain;
    logic [c_PROD_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_scaled;

    assign w_rise   = r_en_s & ~r_en_d;
    assign w_fall   = ~r_en_s & r_en_d;
    assign w_tick   = (r_state == S_PLAY) && (r_tick_cnt == c_TICK_LAST);
    assign w_at_end = (r_rd_addr == r_end);
    // A falling enable on the same clock as the end tick suppresses done.
    assign w_finish = w_tick && w_at_end && !loop_en && !w_fall;

    assign w_play_next = (r_state == S_IDLE) ? w_rise : !(w_fall || w_finish);

    // (volume+1) <= 2^VOL_W, so the shifted product always fits DATA_W bits.
    assign w_gain   = {1'b0, volume} + c_GAIN_W'(1);
    assign w_prod   = c_PROD_W'(rd_data) * c_PROD_W'(w_gain);
    assign w_scaled = DATA_W'(w_prod >> VOL_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_en_s  <= 1'b0;
            r_en_d  <= 1'b0;
        end else begin
            r_sync1 <= aud_en;
            r_en_s  <= r_sync1;
            r_en_d  <= r_en_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start    <= '0;
            r_end      <= '0;
            r_rd_addr  <= '0;
            r_tick_cnt <= '0;
            r_sample   <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state    <= S_PLAY;
                        r_start    <= start_addr;
                        r_end      <= end_addr;
                        r_rd_addr  <= start_addr;
                        r_tick_cnt <= '0;
                        r_sample   <= '0;
                    end
                end
                S_PLAY: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_TICK_W'(1);
                        if (w_tick) begin
                            r_sample <= w_scaled;
                            if (!w_at_end) begin
                                r_rd_addr <= r_rd_addr + ADDR_W'(1);
                            end else if (loop_en) begin
                                r_rd_addr <= r_start;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            r_done <= w_finish;
        end
    end

    // Duty only reloads at the period boundary so a period is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + DATA_W'(1);
            if (!w_play_next) begin
                r_duty <= '0;
            end else if (r_pwm_cnt == c_PWM_LAST) begin
                r_duty <= r_sample;
            end
            r_pwm <= w_play_next && (r_pwm_cnt < r_duty);
        end
    end

    assign rd_addr = r_rd_addr;
    assign pwm     = r_pwm;
    assign busy    = (r_state == S_PLAY);
    assign done    = r_done;

endmodule
`default_nettype wire
